side_buff_inject: RTL and testbench
===================================

SIDE_BUFF_INJECT -- requirements
Module: side_buff_inject

Interface
REQ-001 SHALL have parameter DEPTH, default 4, side-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIM, default 8, consecutive full-and-blocked cycles before forced redirect.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports ead, wad, nad, sad  input  11 each  lanes 0..3 (east, west, north, south) from the eject stage; all-zero word = empty lane.
REQ-006 SHALL have port sbuff  input  11  flit diverted to the side buffer by the eject stage; all-zero = none.
REQ-007 SHALL have ports e_out, w_out, n_out, s_out  output  11 each  registered lanes to the permutation stage.
REQ-008 SHALL have port buff_full  output  1  registered; high when occupancy == DEPTH.
REQ-009 SHALL have port buff_cnt  output  $clog2(DEPTH)+1  registered occupancy.

Function
REQ-010 SHALL store side-buffer flits in a FIFO (head/tail pointers wrapping modulo DEPTH).
REQ-011 SHALL push non-zero sbuff when occupancy < DEPTH, or when occupancy == DEPTH and a pop occurs the same cycle.
REQ-012 SHALL discard non-zero sbuff arriving when full with no same-cycle pop, and SHALL set sticky status bit ovf_err (internal, visible to the bench hierarchically); the eject stage must not divert while buff_full is high.
REQ-013 SHALL pop the head when FIFO non-empty and at least one input lane is empty, placing it in the lowest-index empty lane (priority east, west, north, south).
REQ-014 SHALL pop at most one flit per cycle.
REQ-015 SHALL pass all other lanes through unchanged; every output lane updates one cycle after its inputs (latency 1).
REQ-016 SHALL make a flit pushed in cycle t eligible for pop no earlier than cycle t+1 (no bypass).
REQ-017 SHALL leave occupancy unchanged on simultaneous push and pop.
REQ-018 SHALL never duplicate or lose a flit other than per REQ-012.
REQ-019 SHALL maintain a starve counter: increment each cycle with FIFO full and no pop; clear on any pop; saturate at STARVE_LIM.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear all output lanes to 11'b0, pointers, occupancy, buff_full, buff_cnt, starve counter and ovf_err.
REQ-021 SHALL discard buffered flits on reset mid-operation; first valid output follows the first clk edge after rst_n deasserts.

Configuration
REQ-022 With SIDE_BUFF_REDIRECT_EN defined: when starve counter == STARVE_LIM and all four lanes occupied, SHALL swap: east-lane input flit is pushed to the FIFO tail and the head is driven on e_out in the same cycle; counter clears; occupancy unchanged.
REQ-023 Without SIDE_BUFF_REDIRECT_EN: no redirect logic; a full buffer waits indefinitely for an empty lane; starve counter still present for status.

Structure
REQ-024 SHALL take FLIT_W (11), lane index constants (EAST=0, WEST=1, NORTH=2, SOUTH=3) and the empty-flit constant from the shared router package.
REQ-025 SHALL instantiate one sub-module, side_fifo (DEPTH x FLIT_W, push/pop/full/empty/count), with lane selection and redirect in the top level.

Verification
REQ-026 Push sbuff=11'b00011001100 with all lanes occupied, then wad=0 next cycle -> w_out=11'b00011001100 one cycle later, buff_cnt 1->0.
REQ-027 Two empty lanes (ead=0, nad=0), one buffered flit -> flit on e_out, n_out=0, other lanes passed through.
REQ-028 Fill to DEPTH=4 -> buff_full=1; further sbuff with no empty lane -> ovf_err=1, buff_cnt stays 4.
REQ-029 Full buffer, lane empty and sbuff non-zero same cycle -> pop to lane and push both occur, buff_cnt stays 4, order preserved.
REQ-030 SIDE_BUFF_REDIRECT_EN, full, all lanes occupied for 8 cycles -> cycle 9 e_out=head flit, old ead flit enters tail, buff_cnt=4.
REQ-031 Assert rst_n low with 3 buffered flits -> all outputs 0, buff_cnt=0 immediately, no stale flit after release.

Source files
------------

// File: rtl/side_buff_inject_pkg.sv
// Shared router definitions: flit width, lane indices and the empty-flit encoding.
package side_buff_inject_pkg;

  localparam int FLIT_W  = 11;
  localparam int N_LANES = 4;

  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;

  typedef logic [FLIT_W-1:0] flit_t;

  localparam flit_t EMPTY_FLIT = '0;

  function automatic logic is_empty(input flit_t f);
    return f == EMPTY_FLIT;
  endfunction

endpackage

// File: rtl/side_fifo.sv
// Side-buffer FIFO: DEPTH entries, power-of-two pointers wrapping naturally.
// A push while full is accepted only together with a pop; no write-to-read bypass.
module side_fifo
  import side_buff_inject_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/side_buff_inject.sv
// Side-buffer re-injection stage: buffered flits refill the lowest empty lane.
// Optional starvation redirect is enabled with `define SIDE_BUFF_REDIRECT_EN.
module side_buff_inject
  import side_buff_inject_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FLIT_W-1:0]      ead,
  input  logic [FLIT_W-1:0]      wad,
  input  logic [FLIT_W-1:0]      nad,
  input  logic [FLIT_W-1:0]      sad,
  input  logic [FLIT_W-1:0]      sbuff,
  output logic [FLIT_W-1:0]      e_out,
  output logic [FLIT_W-1:0]      w_out,
  output logic [FLIT_W-1:0]      n_out,
  output logic [FLIT_W-1:0]      s_out,
  output logic                   buff_full,
  output logic [$clog2(DEPTH):0] buff_cnt
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  flit_t       lanes  [N_LANES];
  flit_t       out_p1 [N_LANES];
  flit_t       head;
  flit_t       push_data;
  logic [1:0]  sel;
  logic        any_empty;
  logic        pop_req;
  logic        redirect;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        drop;
  logic [SW-1:0] starve_cnt;
  logic        ovf_err;

  assign lanes[EAST]  = ead;
  assign lanes[WEST]  = wad;
  assign lanes[NORTH] = nad;
  assign lanes[SOUTH] = sad;

  // Scan from the highest index down so the lowest-index empty lane wins.
  always_comb begin
    any_empty = 1'b0;
    sel       = 2'(EAST);
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (is_empty(lanes[i])) begin
        any_empty = 1'b1;
        sel       = 2'(i);
      end
    end
  end

  assign pop_req = !fifo_empty && any_empty;

`ifdef SIDE_BUFF_REDIRECT_EN
  assign redirect = fifo_full && !any_empty && (starve_cnt == SW'(STARVE_LIM));
`else
  assign redirect = 1'b0;
`endif

  // On a redirect the push slot is taken by the east flit, so a diverted flit is lost.
  assign fifo_pop  = pop_req || redirect;
  assign fifo_push = redirect || !is_empty(sbuff);
  assign push_data = redirect ? ead : sbuff;
  assign drop      = !is_empty(sbuff) && (redirect || (fifo_full && !pop_req));

  side_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FLIT_W)
  ) u_side_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (buff_cnt)
  );

  assign buff_full = fifo_full;

  // Stage p1: registered lanes, starve counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANES; i++) out_p1[i] <= EMPTY_FLIT;
      starve_cnt <= '0;
      ovf_err    <= 1'b0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        out_p1[i] <= (pop_req && (sel == 2'(i))) ? head : lanes[i];
      end
      if (redirect) out_p1[EAST] <= head;

      if (fifo_pop)
        starve_cnt <= '0;
      else if (fifo_full && (starve_cnt != SW'(STARVE_LIM)))
        starve_cnt <= starve_cnt + 1'b1;

      if (drop) ovf_err <= 1'b1;
    end
  end

  assign e_out = out_p1[EAST];
  assign w_out = out_p1[WEST];
  assign n_out = out_p1[NORTH];
  assign s_out = out_p1[SOUTH];

endmodule

// File: tb/tb_side_buff_inject.sv
// Scoreboard bench for side_buff_inject; honours `define SIDE_BUFF_REDIRECT_EN.
module tb_side_buff_inject;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] ead = '0, wad = '0, nad = '0, sad = '0, sbuff = '0;
  logic [10:0] e_out, w_out, n_out, s_out;
  logic        buff_full;
  logic [2:0]  buff_cnt;

  always #5 clk = ~clk;

  side_buff_inject #(.DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ead(ead), .wad(wad), .nad(nad), .sad(sad), .sbuff(sbuff),
    .e_out(e_out), .w_out(w_out), .n_out(n_out), .s_out(s_out),
    .buff_full(buff_full), .buff_cnt(buff_cnt)
  );

  typedef struct packed {
    logic [10:0] e, w, n, s;
    logic        full;
    logic [2:0]  cnt;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [10:0] mq[$];
  exp_t        sb_q[$];
  int          sc = 0;
  logic        movf = 1'b0;

  localparam logic [10:0] A = 11'h101, B = 11'h202, C = 11'h304, D = 11'h408;

  function automatic exp_t actual();
    return {e_out, w_out, n_out, s_out, buff_full, buff_cnt};
  endfunction

  // Drive one cycle of stimulus, run the reference model, queue the expected outputs.
  task automatic drive(input logic [10:0] e, w, n, s, sb);
    logic [10:0] l[4];
    bit pop, redir;
    int sel, sz0;
    exp_t x;
    @(negedge clk);
    ead = e; wad = w; nad = n; sad = s; sbuff = sb;
    l = '{e, w, n, s};
    sz0 = mq.size();
    pop = 0; sel = 0; redir = 0;
    if (sz0 > 0)
      for (int i = 3; i >= 0; i--) if (l[i] == 11'd0) begin pop = 1; sel = i; end
`ifdef SIDE_BUFF_REDIRECT_EN
    redir = !pop && sc == LIM && sz0 == DEPTH && e != 0 && w != 0 && n != 0 && s != 0;
`endif
    if (pop) l[sel] = mq.pop_front();
    if (redir) begin
      l[0] = mq.pop_front();
      mq.push_back(e);
      if (sb != 0) movf = 1'b1;
    end else if (sb != 0) begin
      if (sz0 < DEPTH || pop) mq.push_back(sb);
      else movf = 1'b1;
    end
    if (pop || redir) sc = 0;
    else if (sz0 == DEPTH && sc < LIM) sc++;
    x.e = l[0]; x.w = l[1]; x.n = l[2]; x.s = l[3];
    x.full = (mq.size() == DEPTH);
    x.cnt  = 3'(mq.size());
    sb_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({e_out, w_out, n_out, s_out, buff_full, buff_cnt} !== 48'd0 || dut.ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: outputs=%h ovf=%b, required all zero", actual(), dut.ovf_err);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_inject_west();
    exp_t x;
    drive(A, B, C, D, 11'b00011001100);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL west_push: got %h need %h", actual(), x); end
    drive(A, 11'd0, C, D, 11'd0);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL west_pop: got %h need %h", actual(), x); end
    tests++;
    if (w_out !== 11'b00011001100 || buff_cnt !== 3'd0) begin
      fails++; $display("FAIL west_lane: w_out=%b cnt=%0d, need 00011001100 cnt 0", w_out, buff_cnt);
    end
  endtask

  task automatic test_two_empty();
    exp_t x;
    drive(A, B, C, D, 11'h555);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL two_empty_push: got %h need %h", actual(), x); end
    drive(11'd0, B, 11'd0, D, 11'd0);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL two_empty_pop: got %h need %h", actual(), x); end
    tests++;
    if (e_out !== 11'h555 || w_out !== B || n_out !== 11'd0 || s_out !== D) begin
      fails++; $display("FAIL two_empty_lanes: e=%h w=%h n=%h s=%h need 555 %h 000 %h", e_out, w_out, n_out, s_out, B, D);
    end
  endtask

  task automatic test_fill_overflow();
    exp_t x;
    for (int k = 0; k < DEPTH; k++) begin
      drive(A, B, C, D, 11'(16 + k));
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL fill[%0d]: got %h need %h", k, actual(), x); end
    end
    tests++;
    if (buff_full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b need 1", buff_full); end
    drive(A, B, C, D, 11'h7AA);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL ovf_cycle: got %h need %h", actual(), x); end
    tests++;
    if (dut.ovf_err !== 1'b1 || buff_cnt !== 3'd4) begin
      fails++; $display("FAIL ovf_flag: ovf=%b cnt=%0d need 1 and 4", dut.ovf_err, buff_cnt);
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(11'd0, 11'd0, 11'd0, 11'd0, 11'd0);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL drain_ovf[%0d]: got %h need %h", k, actual(), x); end
      tests++;
      if (e_out !== 11'(16 + k)) begin fails++; $display("FAIL drain_order[%0d]: got %h need %h", k, e_out, 11'(16 + k)); end
    end
  endtask

  task automatic test_full_push_pop();
    exp_t x;
    for (int k = 0; k < DEPTH; k++) begin
      drive(A, B, C, D, 11'(32 + k));
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL pp_fill[%0d]: got %h need %h", k, actual(), x); end
    end
    drive(11'd0, B, C, D, 11'h3C3);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL pp_both: got %h need %h", actual(), x); end
    tests++;
    if (buff_cnt !== 3'd4 || e_out !== 11'd32) begin
      fails++; $display("FAIL pp_count: cnt=%0d e=%h need 4 and 020", buff_cnt, e_out);
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(A, 11'd0, C, D, 11'd0);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL pp_drain[%0d]: got %h need %h", k, actual(), x); end
    end
    tests++;
    if (w_out !== 11'h3C3) begin fails++; $display("FAIL pp_order: last w=%h need 3c3", w_out); end
  endtask

  task automatic test_starve();
    exp_t x;
    logic [10:0] e9;
    e9 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(A, B, C, D, 11'(48 + k));
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL st_fill[%0d]: got %h need %h", k, actual(), x); end
    end
    for (int k = 0; k < 10; k++) begin
      drive(11'(64 + k), B, C, D, 11'd0);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL starve[%0d]: got %h need %h", k, actual(), x); end
      if (k == LIM) e9 = e_out;
    end
`ifdef SIDE_BUFF_REDIRECT_EN
    tests++;
    if (e9 !== 11'd48 || buff_cnt !== 3'd4) begin
      fails++; $display("FAIL redirect: e_out=%h cnt=%0d need 030 and 4", e9, buff_cnt);
    end
`else
    tests++;
    if (dut.starve_cnt !== 4'(LIM) || e9 !== 11'(64 + LIM)) begin
      fails++; $display("FAIL starve_sat: cnt=%0d e=%h need %0d and %h", dut.starve_cnt, e9, LIM, 11'(64 + LIM));
    end
`endif
    for (int k = 0; k < DEPTH; k++) begin
      drive(11'd0, B, C, D, 11'd0);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL st_drain[%0d]: got %h need %h", k, actual(), x); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [10:0] l[4];
    logic [10:0] sb;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 2) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      sb = (mq.size() < DEPTH && $urandom_range(0, 1) == 1) ? 11'($urandom_range(1, 2047)) : 11'd0;
      drive(l[0], l[1], l[2], l[3], sb);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL b2b[%0d]: got %h need %h", k, actual(), x); end
    end
    for (int k = 0; k <= DEPTH; k++) begin
      drive(11'd0, 11'd0, 11'd0, 11'd0, 11'd0);
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL b2b_drain[%0d]: got %h need %h", k, actual(), x); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    for (int k = 0; k < 3; k++) begin
      drive(A, B, C, D, 11'(80 + k));
      x = sb_q.pop_front(); tests++;
      if (actual() !== x) begin fails++; $display("FAIL rm_fill[%0d]: got %h need %h", k, actual(), x); end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({e_out, w_out, n_out, s_out, buff_full, buff_cnt} !== 48'd0 || dut.ovf_err !== 1'b0) begin
      fails++; $display("FAIL reset_async: outputs=%h ovf=%b need zero", actual(), dut.ovf_err);
    end
    mq.delete(); sc = 0; movf = 1'b0;
    ead = '0; wad = '0; nad = '0; sad = '0; sbuff = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(11'd0, B, 11'd0, D, 11'd0);
    x = sb_q.pop_front(); tests++;
    if (actual() !== x) begin fails++; $display("FAIL rm_after: got %h need %h", actual(), x); end
    tests++;
    if (e_out !== 11'd0 || n_out !== 11'd0 || buff_cnt !== 3'd0) begin
      fails++; $display("FAIL rm_stale: e=%h n=%h cnt=%0d need 0 0 0", e_out, n_out, buff_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_inject_west();
    test_two_empty();
    test_fill_overflow();
    test_full_push_pop();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
